muldiv_ctrl: RTL and testbench

Sequencer between the multicycle CPU control unit and the two iterative arithmetic units: the Booth multiplier and the restoring divider. It accepts one MULT/DIV request at a time and latches the operands. It launches the selected unit with a one-cycle start pulse and waits for that unit's completion flag. It then commits the result into the architectural HI/LO registers and signals completion. While an operation is in flight it stalls the control unit and reports divide-by-zero.

---
 rtl/muldiv_ctrl_if.sv | 32 +++
 rtl/muldiv_ctrl.sv | 153 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// CPU-side request/response bundle for muldiv_ctrl.
// Optional macro MULDIV_TIMEOUT_EN adds the timeout pulse.
interface muldiv_ctrl_if #(
    parameter int unsigned W = 32
) ();
    logic         start;
    logic         op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div0;
`ifdef MULDIV_TIMEOUT_EN
    logic         timeout;

    // Control unit side
    modport master (output start, op, x, y,
                    input  hi, lo, busy, done, div0, timeout);
    // Sequencer side
    modport slave  (input  start, op, x, y,
                    output hi, lo, busy, done, div0, timeout);
`else
    // Control unit side
    modport master (output start, op, x, y,
                    input  hi, lo, busy, done, div0);
    // Sequencer side
    modport slave  (input  start, op, x, y,
                    output hi, lo, busy, done, div0);
`endif
endinterface

// File: rtl/muldiv_ctrl.sv
// MULT/DIV sequencer: latches one request, launches the Booth multiplier or
// the restoring divider, waits for its fim, then commits HI/LO.
// Optional macro MULDIV_TIMEOUT_EN enables a WAIT-state watchdog that aborts
// after TIMEOUT cycles without fim and pulses cpu.timeout.
module muldiv_ctrl #(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  cpu,
    output logic          mult_start,
    output logic          div_start,
    output logic [W-1:0]  unit_x,
    output logic [W-1:0]  unit_y,
    input  logic [W-1:0]  mult_hi,
    input  logic [W-1:0]  mult_lo,
    input  logic          mult_fim,
    input  logic [W-1:0]  div_hi,
    input  logic [W-1:0]  div_lo,
    input  logic          div_fim
);

    // Watchdog counter must be able to hold TIMEOUT
    if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cnt_w_check
        $error("muldiv_ctrl: CNT_W too small for TIMEOUT");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_REJECT
    } state_t;

    state_t       state;
    logic         op_q;
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;
    logic [W-1:0] hi_stg;
    logic [W-1:0] lo_stg;
    logic         busy_q;
    logic         done_q;
    logic         div0_q;
    logic         sel_fim;
`ifdef MULDIV_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;

    assign cpu.timeout = timeout_q;
`endif

    assign cpu.hi   = hi_q;
    assign cpu.lo   = lo_q;
    assign cpu.busy = busy_q;
    assign cpu.done = done_q;
    assign cpu.div0 = div0_q;

    // Only the launched unit's completion flag is observed
    assign sel_fim = op_q ? div_fim : mult_fim;

    // Sequencer FSM; every output is registered and set on the transition
    // into the state in which it is visible
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            op_q       <= 1'b0;
            unit_x     <= '0;
            unit_y     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            hi_stg     <= '0;
            lo_stg     <= '0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div0_q     <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            wd_cnt     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            done_q     <= 1'b0;
            div0_q     <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (cpu.start) begin
                        op_q   <= cpu.op;
                        unit_x <= cpu.x;
                        unit_y <= cpu.y;
                        busy_q <= 1'b1;
                        if (cpu.op && (cpu.y == '0)) begin
                            state  <= S_REJECT;
                            done_q <= 1'b1;
                            div0_q <= 1'b1;
                        end else begin
                            state      <= S_LAUNCH;
                            mult_start <= ~cpu.op;
                            div_start  <= cpu.op;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
`ifdef MULDIV_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (sel_fim) begin
                        hi_stg <= op_q ? div_hi : mult_hi;
                        lo_stg <= op_q ? div_lo : mult_lo;
                        state  <= S_WRITE;
                        done_q <= 1'b1;
                    end
`ifdef MULDIV_TIMEOUT_EN
                    else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Abort reuses the reject path with div0 low
                        state     <= S_REJECT;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
`endif
                end
                S_WRITE: begin
                    hi_q   <= hi_stg;
                    lo_q   <= lo_stg;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                S_REJECT: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider models.
// Cycle offsets are counted from the start cycle (offset 0); done for a unit
// of latency N lands at offset N+2 (N+3 cycles inclusive of the start cycle).
module tb_muldiv_ctrl;

    localparam int unsigned W      = 32;
    localparam int          BUDGET = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         mult_start;
    logic         div_start;
    logic [W-1:0] unit_x;
    logic [W-1:0] unit_y;
    logic [W-1:0] mult_hi;
    logic [W-1:0] mult_lo;
    logic         mult_fim;
    logic [W-1:0] div_hi;
    logic [W-1:0] div_lo;
    logic         div_fim_m;
    logic         div_fim_s;
    logic         div_fim;

    muldiv_ctrl_if #(.W(W)) cpu ();

    assign div_fim = div_fim_m | div_fim_s;

    muldiv_ctrl #(.W(W), .TIMEOUT(40), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu),
        .mult_start (mult_start),
        .div_start  (div_start),
        .unit_x     (unit_x),
        .unit_y     (unit_y),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .mult_fim   (mult_fim),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .div_fim    (div_fim)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Unit latency (start pulse to fim) and enables for the models
    int mult_n  = 1;
    int div_n   = 1;
    bit mult_en = 1'b1;
    bit div_en  = 1'b1;

    // Signed multiplier model
    initial begin : mult_model
        logic signed [2*W-1:0] a;
        logic signed [2*W-1:0] b;
        logic signed [2*W-1:0] p;
        mult_fim = 1'b0;
        mult_hi  = 32'hDEADBEEF;
        mult_lo  = 32'hDEADBEEF;
        forever begin
            @(posedge clk); #1;
            if (mult_start && mult_en) begin
                a = {{W{unit_x[W-1]}}, unit_x};
                b = {{W{unit_y[W-1]}}, unit_y};
                p = a * b;
                repeat (mult_n) @(posedge clk);
                #1;
                mult_fim = 1'b1;
                mult_hi  = p[2*W-1:W];
                mult_lo  = p[W-1:0];
                @(posedge clk); #1;
                mult_fim = 1'b0;
                mult_hi  = 32'hDEADBEEF;
                mult_lo  = 32'hDEADBEEF;
            end
        end
    end

    // Signed divider model: hi = remainder, lo = quotient
    initial begin : div_model
        logic signed [2*W-1:0] a;
        logic signed [2*W-1:0] b;
        logic signed [2*W-1:0] q;
        logic signed [2*W-1:0] r;
        div_fim_m = 1'b0;
        div_hi    = 32'hBADC0DE0;
        div_lo    = 32'hBADC0DE0;
        forever begin
            @(posedge clk); #1;
            if (div_start && div_en) begin
                a = {{W{unit_x[W-1]}}, unit_x};
                b = {{W{unit_y[W-1]}}, unit_y};
                q = a / b;
                r = a % b;
                repeat (div_n) @(posedge clk);
                #1;
                div_fim_m = 1'b1;
                div_hi    = r[W-1:0];
                div_lo    = q[W-1:0];
                @(posedge clk); #1;
                div_fim_m = 1'b0;
                div_hi    = 32'hBADC0DE0;
                div_lo    = 32'hBADC0DE0;
            end
        end
    end

    // Results of one run_op call
    int           r_done_off;
    int           r_ms_cnt;
    int           r_ms_off;
    int           r_ds_cnt;
    logic         r_div0;
    logic         r_to;
    logic         r_busy_d;
    logic         r_busy_a;
    logic         r_done_a;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_ux;
    logic [W-1:0] r_uy;

    // Issue one request at the current cycle and observe it until one cycle after done
    task automatic run_op(input logic op, input logic [W-1:0] xv, input logic [W-1:0] yv);
        r_done_off = -1;
        r_ms_cnt   = 0;
        r_ms_off   = -1;
        r_ds_cnt   = 0;
        r_div0     = 1'b0;
        r_to       = 1'b0;
        r_busy_d   = 1'b0;
        r_ux       = '0;
        r_uy       = '0;
        cpu.start = 1'b1;
        cpu.op    = op;
        cpu.x     = xv;
        cpu.y     = yv;
        @(posedge clk); #1;
        cpu.start = 1'b0;
        cpu.op    = ~op;
        cpu.x     = 32'hA5A5A5A5;
        cpu.y     = 32'h5A5A5A5A;
        for (int off = 1; off <= BUDGET; off++) begin
            if (mult_start) begin
                r_ms_cnt++;
                if (r_ms_off < 0) r_ms_off = off;
            end
            if (div_start) r_ds_cnt++;
            if (cpu.done) begin
                r_done_off = off;
                r_div0     = cpu.div0;
                r_busy_d   = cpu.busy;
                r_ux       = unit_x;
                r_uy       = unit_y;
`ifdef MULDIV_TIMEOUT_EN
                r_to       = cpu.timeout;
`endif
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        r_busy_a = cpu.busy;
        r_done_a = cpu.done;
        r_hi     = cpu.hi;
        r_lo     = cpu.lo;
    endtask

    typedef struct {
        logic         op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           n;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         ediv0;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    int   cnt_done;
    int   cnt_busy;
    int   cnt_ds;
    int   exp_off;

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vt[0] = '{1'b0, 32'd3,        32'hFFFFFFFE, 33, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vt[1] = '{1'b1, 32'd7,        32'd2,        33, 32'd1,        32'd3,        1'b0};
        vt[2] = '{1'b0, 32'h00010000, 32'h00010000, 1,  32'd1,        32'd0,        1'b0};
        vt[3] = '{1'b1, 32'hFFFFFFF9, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[4] = '{1'b0, 32'd5,        32'd0,        3,  32'd0,        32'd0,        1'b0};
        vt[5] = '{1'b1, 32'h80000000, 32'd1,        4,  32'd0,        32'h80000000, 1'b0};
        vt[6] = '{1'b0, 32'hFFFFFFFB, 32'hFFFFFFF9, 2,  32'd0,        32'h00000023, 1'b0};
        vt[7] = '{1'b0, 32'h66666666, 32'h2AAAAAAB, 7,  32'h11111111, 32'h22222222, 1'b0};
        vt[8] = '{1'b1, 32'd5,        32'd0,        0,  32'h11111111, 32'h22222222, 1'b1};
        vt[9] = '{1'b1, 32'd100,      32'hFFFFFFF9, 6,  32'd2,        32'hFFFFFFF2, 1'b0};

        reset     = 1'b0;
        cpu.start = 1'b0;
        cpu.op    = 1'b0;
        cpu.x     = '0;
        cpu.y     = '0;
        div_fim_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi",         64'(cpu.hi),     64'd0);
        chk("reset lo",         64'(cpu.lo),     64'd0);
        chk("reset busy",       64'(cpu.busy),   64'd0);
        chk("reset done",       64'(cpu.done),   64'd0);
        chk("reset div0",       64'(cpu.div0),   64'd0);
        chk("reset mult_start", 64'(mult_start), 64'd0);
        chk("reset div_start",  64'(div_start),  64'd0);
        chk("reset unit_x",     64'(unit_x),     64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven operations
        for (int i = 0; i < NV; i++) begin
            mult_n = vt[i].n;
            div_n  = vt[i].n;
            run_op(vt[i].op, vt[i].x, vt[i].y);
            exp_off = vt[i].ediv0 ? 1 : vt[i].n + 2;
            chk($sformatf("v%0d done_offset", i), 64'(r_done_off), 64'(exp_off));
            chk($sformatf("v%0d mult_start_count", i), 64'(r_ms_cnt),
                64'((!vt[i].op) ? 1 : 0));
            if (!vt[i].op)
                chk($sformatf("v%0d mult_start_offset", i), 64'(r_ms_off), 64'd1);
            chk($sformatf("v%0d div_start_count", i), 64'(r_ds_cnt),
                64'((vt[i].op && !vt[i].ediv0) ? 1 : 0));
            chk($sformatf("v%0d div0", i),            64'(r_div0),   64'(vt[i].ediv0));
            chk($sformatf("v%0d busy_at_done", i),    64'(r_busy_d), 64'd1);
            chk($sformatf("v%0d unit_x_held", i),     64'(r_ux),     64'(vt[i].x));
            chk($sformatf("v%0d unit_y_held", i),     64'(r_uy),     64'(vt[i].y));
            chk($sformatf("v%0d busy_after", i),      64'(r_busy_a), 64'd0);
            chk($sformatf("v%0d done_after", i),      64'(r_done_a), 64'd0);
            chk($sformatf("v%0d hi", i),              64'(r_hi),     64'(vt[i].ehi));
            chk($sformatf("v%0d lo", i),              64'(r_lo),     64'(vt[i].elo));
        end

        // Stray DIV request and spurious div_fim while a MULT is in WAIT
        mult_n = 20;
        fork
            run_op(1'b0, 32'd6, 32'd7);
            begin
                repeat (5) @(posedge clk);
                #1;
                cpu.start = 1'b1;
                cpu.op    = 1'b1;
                cpu.x     = 32'd9;
                cpu.y     = 32'd3;
                div_fim_s = 1'b1;
                @(posedge clk); #1;
                cpu.start = 1'b0;
                div_fim_s = 1'b0;
            end
        join
        chk("stray done_offset",     64'(r_done_off), 64'd22);
        chk("stray div_start_count", 64'(r_ds_cnt),   64'd0);
        chk("stray hi",              64'(r_hi),       64'd0);
        chk("stray lo",              64'(r_lo),       64'd42);
        cnt_done = 0;
        cnt_busy = 0;
        cnt_ds   = 0;
        repeat (10) begin
            if (cpu.done) cnt_done++;
            if (cpu.busy) cnt_busy++;
            if (div_start) cnt_ds++;
            @(posedge clk); #1;
        end
        chk("stray not_queued_done", 64'(cnt_done), 64'd0);
        chk("stray not_queued_busy", 64'(cnt_busy), 64'd0);
        chk("stray not_queued_div",  64'(cnt_ds),   64'd0);

        // Reset pulse during WAIT; the late mult_fim must be ignored
        mult_n    = 10;
        cpu.start = 1'b1;
        cpu.op    = 1'b0;
        cpu.x     = 32'd4;
        cpu.y     = 32'd5;
        @(posedge clk); #1;
        cpu.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset busy_before", 64'(cpu.busy), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midreset busy", 64'(cpu.busy), 64'd0);
        chk("midreset hi",   64'(cpu.hi),   64'd0);
        chk("midreset lo",   64'(cpu.lo),   64'd0);
        cnt_done = 0;
        cnt_busy = 0;
        repeat (15) begin
            if (cpu.done) cnt_done++;
            if (cpu.busy) cnt_busy++;
            @(posedge clk); #1;
        end
        chk("midreset no_done", 64'(cnt_done), 64'd0);
        chk("midreset no_busy", 64'(cnt_busy), 64'd0);
        chk("midreset lo_after_fim", 64'(cpu.lo), 64'd0);

        // Normal operation after the abort
        mult_n = 2;
        run_op(1'b0, 32'd3, 32'hFFFFFFFE);
        chk("post_reset done_offset", 64'(r_done_off), 64'd4);
        chk("post_reset hi",          64'(r_hi),       64'hFFFFFFFF);
        chk("post_reset lo",          64'(r_lo),       64'hFFFFFFFA);

`ifdef MULDIV_TIMEOUT_EN
        // Unit never completes: watchdog aborts 40 cycles after WAIT entry
        mult_en = 1'b0;
        run_op(1'b0, 32'd2, 32'd3);
        mult_en = 1'b1;
        chk("timeout done_offset", 64'(r_done_off), 64'd42);
        chk("timeout pulse",       64'(r_to),       64'd1);
        chk("timeout div0",        64'(r_div0),     64'd0);
        chk("timeout busy_after",  64'(r_busy_a),   64'd0);
        chk("timeout hi",          64'(r_hi),       64'hFFFFFFFF);
        chk("timeout lo",          64'(r_lo),       64'hFFFFFFFA);
        mult_n = 3;
        run_op(1'b0, 32'd2, 32'd3);
        chk("after_timeout done_offset", 64'(r_done_off), 64'd5);
        chk("after_timeout pulse",       64'(r_to),       64'd0);
        chk("after_timeout lo",          64'(r_lo),       64'd6);
`else
        // Without the watchdog a silent unit holds the sequencer in WAIT
        mult_en   = 1'b0;
        cpu.start = 1'b1;
        cpu.op    = 1'b0;
        cpu.x     = 32'd2;
        cpu.y     = 32'd3;
        @(posedge clk); #1;
        cpu.start = 1'b0;
        cnt_done = 0;
        cnt_busy = 0;
        repeat (60) begin
            if (cpu.done) cnt_done++;
            if (cpu.busy) cnt_busy++;
            @(posedge clk); #1;
        end
        chk("hang no_done",   64'(cnt_done), 64'd0);
        chk("hang busy_held", 64'(cnt_busy), 64'd60);
        reset = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b1;
        mult_en = 1'b1;
        chk("hang reset_busy", 64'(cpu.busy), 64'd0);
        mult_n = 3;
        run_op(1'b0, 32'd2, 32'd3);
        chk("after_hang done_offset", 64'(r_done_off), 64'd5);
        chk("after_hang lo",          64'(r_lo),       64'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
